game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Round controller for the memory game. Latches the difficulty level and generates a pseudo-random button pattern of 8, 12 or 16 entries, then plays it on the 8 LEDs.
- Then releases the input-trim block from reset, waits for its end signal, and compares the captured entries against the pattern.
- Reports pass/fail, the first mismatch index and a running score. It sits between the top-level FSM/UI and the input-trim datapath, and is the only driver of that block's reset.

Parameters:
SHOW_CYCLES, 25000000, cycles each pattern LED is lit
GAP_CYCLES, 12500000, dark cycles between pattern LEDs
TIMEOUT_CYCLES, 500000000, maximum cycles allowed in the input phase
CNT_W, 32, width of the shared phase timer

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse: begin a round; ignored while busy=1
level  in  2  difficulty 1..3; value 0 treated as 1; sampled only on accepted start
seed  in  16  LFSR seed, sampled on accepted start; 0 replaced by 16'hACE1
trim_end  in  1  end signal from input-trim block
trim_data  in  48  captured entries; entry k at bits [3k+2:3k], values 0..7
trim_rst_n  out  1  active-low reset to input-trim block
trim_level  out  2  latched (clamped) level driven to input-trim block
led_onehot  out  8  pattern display; bit v lit for value v
busy  out  1  high in every state except IDLE
phase  out  3  current state encoding
result_valid  out  1  one-cycle pulse when a round ends
result_pass  out  1  round outcome, held until next result
timeout  out  1  round failed by timeout, held until next result
mismatch_idx  out  4  first wrong entry; 4'hF on timeout; 0 on pass
score  out  8  cumulative score, saturating

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; all outputs 0, including trim_rst_n=0 (trim block held in reset); pattern registers are don't-care. Reset mid-round aborts immediately with no result pulse.
- N = 4+4*L, where L = latched level (0 maps to 1): L=1 gives 8, L=2 gives 12, L=3 gives 16.
- States and encodings: IDLE=0, GEN=1, SHOW_ON=2, SHOW_OFF=3, INPUT=4, CHECK=5, RESULT=6.
- IDLE: on start=1, latch L and seed, clear k, go to GEN.
- GEN: for each of N cycles: pattern[k] <= lfsr[2:0], advance LFSR one step, k++. Go to SHOW_ON after N cycles.
  - LFSR: 16-bit Fibonacci, taps 16,14,13,11; shift left, feedback into bit 0.
- SHOW_ON: led_onehot = 1<<pattern[k] for exactly SHOW_CYCLES cycles, then go to SHOW_OFF.
- SHOW_OFF: led_onehot=0 for GAP_CYCLES cycles. Then k++ and return to SHOW_ON; after the last entry, go to INPUT.
- INPUT:
  - trim_rst_n=1 from the first INPUT cycle; timer cleared on entry.
  - trim_end=1 goes to CHECK with k=0. trim_data is stable from the cycle trim_end rises.
  - If the timer reaches TIMEOUT_CYCLES without trim_end, go to RESULT with fail, timeout=1, mismatch_idx=4'hF.
  - If trim_end and timeout occur in the same cycle, trim_end wins.
- CHECK: compare one entry per cycle, trim_data[k] vs pattern[k], for k=0..N-1.
  - First mismatch goes to RESULT with fail, mismatch_idx=k.
  - All N equal goes to RESULT with pass.
  - Entries at k≥N are ignored.
- RESULT, one cycle:
  - result_valid=1; result_pass, timeout and mismatch_idx updated.
  - On pass, score <= min(score+N, 255).
  - trim_rst_n returns to 0 this cycle; next state IDLE.
- trim_rst_n is 0 in all states except INPUT and CHECK.
- start pulses while busy=1 are dropped, not queued. level and seed changes mid-round have no effect.
- Timer: single CNT_W counter, cleared on every state entry. Compares use "== PARAM-1" so durations are exact.

Decomposition:
- Shared package game_pkg:
  - state encoding constants;
  - DEFAULT_SEED (16'hACE1);
  - LFSR tap mask;
  - MAX_LEN=16;
  - a function returning N from a 2-bit level with 0-clamp.
- One sub-module lfsr16 (load, step, seed in, state out), reused by later pattern blocks.

Test Plan:
1. SHOW=4, GAP=2, level=1, seed=16'h0001, start:
   - 8 LED pulses, each exactly 4 cycles high with 2 dark cycles between, values matching the reference LFSR model;
   - trim_rst_n rises on the first INPUT cycle;
   - bench returns matching trim_data and trim_end → result_valid one cycle, result_pass=1, mismatch_idx=0, score=8.
2. level=2, same seed, trim_data entry 5 wrong → result_pass=0, mismatch_idx=5, timeout=0, score unchanged; level=3 run → 16 pattern LED pulses; level=0 → 8 pulses.
3. TIMEOUT=20, no trim_end → result exactly 20 cycles after INPUT entry, timeout=1, mismatch_idx=4'hF, trim_rst_n=0 in the RESULT cycle.
4. start pulses during SHOW_ON and INPUT → no effect on state or pattern; level changed mid-round → N unchanged.
5. rst=1 during SHOW_OFF → next cycle phase=0, led_onehot=0, trim_rst_n=0, busy=0, score=0, no result_valid.
6. 32 consecutive passing level-3 rounds → score saturates at 255, does not wrap; seed=0 gives the same pattern as seed=16'hACE1.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the memory-game round controller: state encoding,
// LFSR constants and the level-to-pattern-length mapping.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GEN      = 3'd1,
    SHOW_ON  = 3'd2,
    SHOW_OFF = 3'd3,
    INPUT    = 3'd4,
    CHECK    = 3'd5,
    RESULT   = 3'd6
  } state_t;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam int          MAX_LEN      = 16;

  function automatic logic [1:0] clamp_level(input logic [1:0] lvl);
    return (lvl == 2'd0) ? 2'd1 : lvl;
  endfunction

  // N = 4 + 4*L
  function automatic logic [4:0] pattern_len(input logic [1:0] lvl);
    logic [1:0] l;
    l = clamp_level(lvl);
    return 5'd4 + {1'b0, l, 2'b00};
  endfunction

  // N - 1, which is simply L followed by two ones
  function automatic logic [3:0] last_index(input logic [1:0] lvl);
    logic [1:0] l;
    l = clamp_level(lvl);
    return {l, 2'b11};
  endfunction

endpackage

// File: rtl/game_sequencer_lfsr16.sv
// 16-bit Fibonacci LFSR, shift-left with feedback into bit 0.
// A zero seed is replaced by the default seed so the register never locks up.
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DEFAULT_SEED;
    end else if (load) begin
      state <= (seed == 16'h0000) ? DEFAULT_SEED : seed;
    end else if (step) begin
      state <= {state[14:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Round controller: generates a pattern, shows it on the LEDs, releases the
// input-trim block, then scores the captured entries against the pattern.
//
//   state    | meaning
//   IDLE     | waiting for start; trim block held in reset
//   GEN      | one pattern entry per cycle from the LFSR
//   SHOW_ON  | current entry lit for SHOW_CYCLES
//   SHOW_OFF | LEDs dark for GAP_CYCLES, then next entry or INPUT
//   INPUT    | trim block running; wait for trim_end or timeout
//   CHECK    | compare one captured entry per cycle
//   RESULT   | one-cycle result pulse
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES    = 25000000,
  parameter int unsigned GAP_CYCLES     = 12500000,
  parameter int unsigned TIMEOUT_CYCLES = 500000000,
  parameter int          CNT_W          = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  level,
  input  logic [15:0] seed,
  input  logic        trim_end,
  input  logic [47:0] trim_data,
  output logic        trim_rst_n,
  output logic [1:0]  trim_level,
  output logic [7:0]  led_onehot,
  output logic        busy,
  output logic [2:0]  phase,
  output logic        result_valid,
  output logic        result_pass,
  output logic        timeout,
  output logic [3:0]  mismatch_idx,
  output logic [7:0]  score
);

  localparam logic [CNT_W-1:0] SHOW_LAST    = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  timer_q;
  logic [3:0]        k_q;
  logic [1:0]        lvl_q;
  logic [2:0]        pattern_q [MAX_LEN];
  logic [15:0]       lfsr_state;
  logic              lfsr_unused;

  logic              lfsr_load, lfsr_step, pat_we;
  logic              k_clr, k_inc;
  logic              res_set, res_pass_d, res_to_d;
  logic [3:0]        res_idx_d;
  logic [3:0]        last_k;
  logic [5:0]        entry_base;
  logic [2:0]        entry;
  logic [8:0]        score_sum;
  logic [7:0]        score_sat;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (seed),
    .state (lfsr_state)
  );

  // only the low three bits form a pattern value
  assign lfsr_unused = ^lfsr_state[15:3];

  assign last_k     = last_index(lvl_q);
  assign entry_base = {2'b00, k_q} + {1'b0, k_q, 1'b0};
  assign entry      = trim_data[entry_base +: 3];
  assign score_sum  = {1'b0, score} + {4'b0000, pattern_len(lvl_q)};
  assign score_sat  = score_sum[8] ? 8'hFF : score_sum[7:0];
  assign trim_level = lvl_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    lfsr_load    = 1'b0;
    lfsr_step    = 1'b0;
    pat_we       = 1'b0;
    k_clr        = 1'b0;
    k_inc        = 1'b0;
    res_set      = 1'b0;
    res_pass_d   = 1'b0;
    res_to_d     = 1'b0;
    res_idx_d    = 4'h0;
    led_onehot   = 8'h00;
    trim_rst_n   = 1'b0;
    busy         = (state_q != IDLE);
    phase        = state_q;
    result_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          lfsr_load = 1'b1;
          k_clr     = 1'b1;
          state_d   = GEN;
        end
      end
      GEN: begin
        pat_we    = 1'b1;
        lfsr_step = 1'b1;
        if (k_q == last_k) begin
          k_clr   = 1'b1;
          state_d = SHOW_ON;
        end else begin
          k_inc = 1'b1;
        end
      end
      SHOW_ON: begin
        led_onehot = 8'h01 << pattern_q[k_q];
        if (timer_q == SHOW_LAST) state_d = SHOW_OFF;
      end
      SHOW_OFF: begin
        if (timer_q == GAP_LAST) begin
          if (k_q == last_k) begin
            k_clr   = 1'b1;
            state_d = INPUT;
          end else begin
            k_inc   = 1'b1;
            state_d = SHOW_ON;
          end
        end
      end
      INPUT: begin
        trim_rst_n = 1'b1;
        // trim_end takes priority over a coincident timeout
        if (trim_end) begin
          k_clr   = 1'b1;
          state_d = CHECK;
        end else if (timer_q == TIMEOUT_LAST) begin
          res_set   = 1'b1;
          res_to_d  = 1'b1;
          res_idx_d = 4'hF;
          state_d   = RESULT;
        end
      end
      CHECK: begin
        trim_rst_n = 1'b1;
        if (entry != pattern_q[k_q]) begin
          res_set   = 1'b1;
          res_idx_d = k_q;
          state_d   = RESULT;
        end else if (k_q == last_k) begin
          res_set    = 1'b1;
          res_pass_d = 1'b1;
          state_d    = RESULT;
        end else begin
          k_inc = 1'b1;
        end
      end
      RESULT: begin
        result_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // result fields and score are loaded on entry so they line up with result_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q      <= '0;
      k_q          <= 4'h0;
      lvl_q        <= 2'd0;
      result_pass  <= 1'b0;
      timeout      <= 1'b0;
      mismatch_idx <= 4'h0;
      score        <= 8'h00;
    end else begin
      timer_q <= (state_d != state_q) ? '0 : timer_q + CNT_W'(1);
      if (lfsr_load) lvl_q <= clamp_level(level);
      if (k_clr)      k_q <= 4'h0;
      else if (k_inc) k_q <= k_q + 4'd1;
      if (res_set) begin
        result_pass  <= res_pass_d;
        timeout      <= res_to_d;
        mismatch_idx <= res_idx_d;
        if (res_pass_d) score <= score_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pat_we) pattern_q[k_q] <= lfsr_state[2:0];
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: each round is expanded into an expected per-cycle
// trace from the round rules, driven in lockstep and compared every cycle.
module tb_game_sequencer;

  localparam int SHOW = 4;
  localparam int GAP  = 2;
  localparam int TMO  = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  level = 2'd0;
  logic [15:0] seed = 16'h0000;
  logic        trim_end = 1'b0;
  logic [47:0] trim_data = '0;
  logic        trim_rst_n;
  logic [1:0]  trim_level;
  logic [7:0]  led_onehot;
  logic        busy;
  logic [2:0]  phase;
  logic        result_valid;
  logic        result_pass;
  logic        timeout;
  logic [3:0]  mismatch_idx;
  logic [7:0]  score;

  game_sequencer #(
    .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .level(level), .seed(seed),
    .trim_end(trim_end), .trim_data(trim_data), .trim_rst_n(trim_rst_n),
    .trim_level(trim_level), .led_onehot(led_onehot), .busy(busy),
    .phase(phase), .result_valid(result_valid), .result_pass(result_pass),
    .timeout(timeout), .mismatch_idx(mismatch_idx), .score(score)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        start;
    logic [1:0]  level;
    logic [15:0] seed;
    logic        trim_end;
    logic [47:0] trim_data;
    logic [2:0]  phase;
    logic [7:0]  led;
    logic        trn;
    logic [1:0]  tl;
    logic        rv;
    logic        rp;
    logic        to;
    logic [3:0]  idx;
    logic [7:0]  score;
    logic        chk_score;
  } cyc_t;

  cyc_t trace[$];
  cyc_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int         m_score = 0;
  logic       m_rp = 1'b0;
  logic       m_to = 1'b0;
  logic [3:0] m_idx = 4'h0;
  logic [1:0] m_lvl = 2'd0;
  logic [2:0] m_pat [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic gen_pattern(input logic [15:0] sd);
    logic [15:0] s;
    s = (sd == 16'h0000) ? 16'hACE1 : sd;
    for (int i = 0; i < 16; i++) begin
      m_pat[i] = s[2:0];
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    end
  endtask

  task automatic drive();
    cyc_t c;
    while (trace.size() > 0) begin
      c = trace.pop_front();
      @(posedge clk);
      #1;
      rst       = c.rst;
      start     = c.start;
      level     = c.level;
      seed      = c.seed;
      trim_end  = c.trim_end;
      trim_data = c.trim_data;
      exp_q.push_back(c);
    end
  endtask

  task automatic idle_cycles(input int n, input logic r);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = '0;
      c.rst = r;
      c.tl = m_lvl; c.rp = m_rp; c.to = m_to; c.idx = m_idx;
      c.score = 8'(m_score); c.chk_score = 1'b1;
      trace.push_back(c);
    end
    drive();
  endtask

  // kind: 0 pass, 1 mismatch at entry mi, 2 timeout; d = INPUT cycles before trim_end
  task automatic run_round(input logic [1:0] lv, input logic [15:0] sd, input int kind,
                           input int mi, input int d, input bit noise, input bit abort);
    cyc_t c;
    int n;
    logic [1:0] L;
    logic [47:0] td;
    L = (lv == 2'd0) ? 2'd1 : lv;
    n = 4 + 4 * int'(L);
    gen_pattern(sd);
    td = '0;
    for (int i = 0; i < 16; i++) td[3*i +: 3] = (i < n) ? m_pat[i] : 3'(i + 3);
    if (kind == 1) td[3*mi +: 3] = m_pat[mi] ^ 3'd1;

    c = '0;
    c.level = lv; c.seed = sd; c.start = 1'b1;
    c.tl = m_lvl; c.rp = m_rp; c.to = m_to; c.idx = m_idx;
    c.score = 8'(m_score); c.chk_score = 1'b1;
    trace.push_back(c);

    c.start = 1'b0;
    if (noise) begin c.level = lv + 2'd1; c.seed = ~sd; end
    c.tl = L;
    c.phase = 3'd1;
    repeat (n) trace.push_back(c);

    for (int i = 0; i < n; i++) begin
      c.phase = 3'd2;
      c.led = 8'd1 << m_pat[i];
      for (int j = 0; j < SHOW; j++) begin
        c.start = noise && (i == 1) && (j == 0);
        trace.push_back(c);
      end
      c.start = 1'b0;
      c.phase = 3'd3;
      c.led = 8'h00;
      for (int j = 0; j < GAP; j++) begin
        if (abort) begin
          c.rst = 1'b1;
          trace.push_back(c);
          c = '0;
          c.chk_score = 1'b1;
          trace.push_back(c);
          m_score = 0; m_rp = 1'b0; m_to = 1'b0; m_idx = 4'h0; m_lvl = 2'd0;
          drive();
          return;
        end
        trace.push_back(c);
      end
    end

    c.phase = 3'd4;
    c.trn = 1'b1;
    if (kind == 2) begin
      for (int j = 0; j < TMO; j++) begin
        c.start = noise && (j == 0);
        trace.push_back(c);
      end
    end else begin
      for (int j = 0; j < d; j++) begin
        c.start = noise && (j == 0);
        trace.push_back(c);
      end
      c.start = 1'b0;
      c.trim_end = 1'b1;
      c.trim_data = td;
      trace.push_back(c);
      c.phase = 3'd5;
      repeat ((kind == 1) ? mi + 1 : n) trace.push_back(c);
    end

    m_rp  = (kind == 0);
    m_to  = (kind == 2);
    m_idx = (kind == 2) ? 4'hF : (kind == 1) ? 4'(mi) : 4'h0;
    if (kind == 0) m_score = (m_score + n > 255) ? 255 : m_score + n;
    m_lvl = L;

    c.start = 1'b0; c.trim_end = 1'b0; c.trim_data = '0; c.trn = 1'b0;
    c.phase = 3'd6; c.rv = 1'b1;
    c.rp = m_rp; c.to = m_to; c.idx = m_idx; c.chk_score = 1'b0;
    trace.push_back(c);
    c.phase = 3'd0; c.rv = 1'b0; c.chk_score = 1'b1; c.score = 8'(m_score);
    trace.push_back(c);
    drive();
  endtask

  initial begin : compare
    cyc_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("phase",        64'(phase),        64'(e.phase));
        chk("busy",         64'(busy),         64'(e.phase != 3'd0));
        chk("led_onehot",   64'(led_onehot),   64'(e.led));
        chk("trim_rst_n",   64'(trim_rst_n),   64'(e.trn));
        chk("trim_level",   64'(trim_level),   64'(e.tl));
        chk("result_valid", 64'(result_valid), 64'(e.rv));
        chk("result_pass",  64'(result_pass),  64'(e.rp));
        chk("timeout",      64'(timeout),      64'(e.to));
        chk("mismatch_idx", 64'(mismatch_idx), 64'(e.idx));
        if (e.chk_score) chk("score", 64'(score), 64'(e.score));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    gen_pattern(16'h0001);
    chk("model_pat_seed1", 64'({m_pat[11], m_pat[3], m_pat[2], m_pat[1], m_pat[0]}),
        64'({3'd1, 3'd0, 3'd4, 3'd2, 3'd1}));
    gen_pattern(16'h0000);
    chk("model_pat_seed0", 64'({m_pat[2], m_pat[1], m_pat[0]}), 64'({3'd7, 3'd3, 3'd1}));

    idle_cycles(3, 1'b1);
    idle_cycles(2, 1'b0);

    run_round(2'd1, 16'h0001, 0, 0, 3, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_score", 64'(score), 64'd8);

    run_round(2'd2, 16'h0001, 1, 5, 2, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_idx", 64'(mismatch_idx), 64'd5);
    chk("t2_score", 64'(score), 64'd8);

    run_round(2'd3, 16'h1234, 0, 0, 1, 1'b0, 1'b0);
    run_round(2'd0, 16'h00FF, 0, 0, 0, 1'b0, 1'b0);

    run_round(2'd1, 16'h5A5A, 2, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_idx", 64'(mismatch_idx), 64'hF);
    chk("t3_timeout", 64'(timeout), 64'd1);

    run_round(2'd2, 16'hBEEF, 0, 0, 4, 1'b1, 1'b0);
    run_round(2'd1, 16'h0F0F, 0, 0, TMO - 1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_score", 64'(score), 64'd52);

    run_round(2'd2, 16'h7777, 0, 0, 0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t5_score", 64'(score), 64'd0);

    for (int r = 0; r < 32; r++) begin
      run_round(2'd3, (r == 0) ? 16'h0000 : (r == 1) ? 16'hACE1 : 16'(r * 977 + 1),
                0, 0, 1, 1'b0, 1'b0);
    end
    @(negedge clk);
    chk("t6_score_sat", 64'(score), 64'd255);

    idle_cycles(2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
